// File: rtl/scene_sequencer_pkg.sv
// Shared types and constants for the scene sequencer: scene codes, FSM states,
// brightness range and the per-scene pixel payload.
package scene_sequencer_pkg;

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned RGB_W   = 12;
    localparam int unsigned ADDR_W  = 17;
    localparam int unsigned LEVEL_W = 5;
    localparam int unsigned STEP_W  = 4;
    localparam int unsigned SCENE_W = 2;

    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 5'd16;

    typedef enum logic [SCENE_W-1:0] {
        SCENE_START = 2'd0,
        SCENE_GAME  = 2'd1,
        SCENE_OVER  = 2'd2
    } scene_e;

    typedef enum logic [2:0] {
        S_START    = 3'd0,
        S_FADE_OUT = 3'd1,
        S_FADE_IN  = 3'd2,
        S_GAME     = 3'd3,
        S_OVER     = 3'd4
    } state_e;

    typedef struct packed {
        logic [RGB_W-1:0]  rgb;
        logic [ADDR_W-1:0] addr;
    } scene_px_t;

endpackage

// File: rtl/scene_sequencer_if.sv
// Bus between the scene renderers / VGA counters and the scene sequencer.
interface scene_sequencer_if;
    import scene_sequencer_pkg::*;

    logic [CNT_W-1:0]   h_cnt;
    logic [CNT_W-1:0]   v_cnt;
    logic               btn_start;
    logic               game_over;
    logic [RGB_W-1:0]   start_vga_data;
    logic [ADDR_W-1:0]  start_pixel_addr;
    logic [RGB_W-1:0]   game_vga_data;
    logic [ADDR_W-1:0]  game_pixel_addr;
    logic [RGB_W-1:0]   over_vga_data;
    logic [ADDR_W-1:0]  over_pixel_addr;
    logic [ADDR_W-1:0]  pixel_addr;
    logic [RGB_W-1:0]   vga_data;
    logic [SCENE_W-1:0] scene;
    logic               game_enable;

    modport master (
        output h_cnt, v_cnt, btn_start, game_over,
        output start_vga_data, start_pixel_addr,
        output game_vga_data, game_pixel_addr,
        output over_vga_data, over_pixel_addr,
        input  pixel_addr, vga_data, scene, game_enable
    );

    modport slave (
        input  h_cnt, v_cnt, btn_start, game_over,
        input  start_vga_data, start_pixel_addr,
        input  game_vga_data, game_pixel_addr,
        input  over_vga_data, over_pixel_addr,
        output pixel_addr, vga_data, scene, game_enable
    );

endinterface

// File: rtl/scene_sequencer_rgb_dimmer.sv
// Combinational RGB444 brightness scaler: each channel becomes (c*level)>>4,
// so level 16 is identity and level 0 is black.
module scene_sequencer_rgb_dimmer
    import scene_sequencer_pkg::*;
(
    input  logic [RGB_W-1:0]   rgb_in,
    input  logic [LEVEL_W-1:0] level,
    output logic [RGB_W-1:0]   rgb_out_c
);

    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        logic [8:0] prod;
        assign prod = 9'(rgb_in[ch*4 +: 4]) * 9'(level);
        assign rgb_out_c[ch*4 +: 4] = 4'(prod >> 4);
    end

endmodule

// File: rtl/scene_sequencer.sv
// Scene controller: sequences start/game/over scenes, muxes their ROM address
// and colour onto the shared path, and fades brightness on every scene change.
module scene_sequencer
    import scene_sequencer_pkg::*;
#(
    parameter int unsigned FRAMES_PER_STEP = 2,
    parameter int unsigned H_VISIBLE       = 640,
    parameter int unsigned V_VISIBLE       = 480
) (
    input  logic              clk,
    input  logic              rst,
    scene_sequencer_if.slave  bus
);

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);

    state_e              state_q, state_d;
    scene_e              disp_q, disp_d;
    scene_e              target_q, target_d;
    logic [LEVEL_W-1:0]  level_q, level_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                start_pend_q, start_pend_d;
    logic                over_pend_q, over_pend_d;
    logic                game_enable_q, game_enable_d;
    logic                frame_start_q;

    logic                frame_start_c;
    logic                frame_tick_c;
    logic                visible_c;
    scene_px_t           px_c;
    logic [RGB_W-1:0]    dim_rgb_c;

    // One-clk pulse on the first cycle of each frame.
    assign frame_start_c = (bus.h_cnt == '0) && (bus.v_cnt == '0);
    assign frame_tick_c  = frame_start_c && !frame_start_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_START;
            disp_q        <= SCENE_START;
            target_q      <= SCENE_START;
            level_q       <= LEVEL_MAX;
            step_q        <= '0;
            start_pend_q  <= 1'b0;
            over_pend_q   <= 1'b0;
            game_enable_q <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            disp_q        <= disp_d;
            target_q      <= target_d;
            level_q       <= level_d;
            step_q        <= step_d;
            start_pend_q  <= start_pend_d;
            over_pend_q   <= over_pend_d;
            game_enable_q <= game_enable_d;
            frame_start_q <= frame_start_c;
        end
    end

    always_comb begin
        state_d      = state_q;
        disp_d       = disp_q;
        target_d     = target_q;
        level_d      = level_q;
        step_d       = step_q;
        start_pend_d = start_pend_q;
        over_pend_d  = over_pend_q;

        case (state_q)
            S_START, S_OVER: begin
                if (frame_tick_c && start_pend_q) begin
                    start_pend_d = 1'b0;
                    target_d     = (state_q == S_START) ? SCENE_GAME : SCENE_START;
                    step_d       = '0;
                    state_d      = S_FADE_OUT;
                end else if (bus.btn_start) begin
                    start_pend_d = 1'b1;
                end
            end
            S_GAME: begin
                if (frame_tick_c && over_pend_q) begin
                    over_pend_d = 1'b0;
                    target_d    = SCENE_OVER;
                    step_d      = '0;
                    state_d     = S_FADE_OUT;
                end else if (bus.game_over) begin
                    over_pend_d = 1'b1;
                end
            end
            S_FADE_OUT: begin
                if (frame_tick_c) begin
                    if (step_q == STEP_LAST) begin
                        step_d  = '0;
                        level_d = level_q - 5'd1;
                        // Scene swap happens only while fully black.
                        if (level_q == 5'd1) begin
                            disp_d  = target_q;
                            state_d = S_FADE_IN;
                        end
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end
            end
            S_FADE_IN: begin
                if (frame_tick_c) begin
                    if (step_q == STEP_LAST) begin
                        step_d  = '0;
                        level_d = level_q + 5'd1;
                        if (level_q == LEVEL_MAX - 5'd1) begin
                            case (disp_q)
                                SCENE_GAME: state_d = S_GAME;
                                SCENE_OVER: state_d = S_OVER;
                                default:    state_d = S_START;
                            endcase
                        end
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end
            end
            default: state_d = S_START;
        endcase

        game_enable_d = (state_d == S_GAME);
    end

    // Source select follows the displayed scene, never the pending target.
    always_comb begin
        case (disp_q)
            SCENE_GAME: px_c = '{rgb: bus.game_vga_data, addr: bus.game_pixel_addr};
            SCENE_OVER: px_c = '{rgb: bus.over_vga_data, addr: bus.over_pixel_addr};
            default:    px_c = '{rgb: bus.start_vga_data, addr: bus.start_pixel_addr};
        endcase
    end

    scene_sequencer_rgb_dimmer u_dimmer (
        .rgb_in    (px_c.rgb),
        .level     (level_q),
        .rgb_out_c (dim_rgb_c)
    );

    assign visible_c = (bus.h_cnt < CNT_W'(H_VISIBLE)) && (bus.v_cnt < CNT_W'(V_VISIBLE));

    assign bus.pixel_addr  = px_c.addr;
    assign bus.vga_data    = visible_c ? dim_rgb_c : '0;
    assign bus.scene       = disp_q;
    assign bus.game_enable = game_enable_q;

endmodule

// File: tb/tb_scene_sequencer.sv
// Bench for scene_sequencer: directed scene walk with randomized pixel data and
// coordinates, checked every cycle against a frame-count-based reference model.
module tb_scene_sequencer;
    import scene_sequencer_pkg::*;

    localparam int FPS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    scene_sequencer_if bus ();

    scene_sequencer #(
        .FRAMES_PER_STEP (FPS),
        .H_VISIBLE       (640),
        .V_VISIBLE       (480)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    // Model: phase 0 idle (start/over screen), 1 fading, 2 game.
    int m_phase, m_disp, m_target, m_t;
    bit m_pend, m_prev_fs;
    bit rand_data = 1'b0;
    bit force_fff = 1'b0;

    // Brightness is |16 - ticks/FPS| while fading, full otherwise.
    function automatic int m_level();
        if (m_phase != 1) return 16;
        return (m_t < 16 * FPS) ? 16 - m_t / FPS : m_t / FPS - 16;
    endfunction

    function automatic logic [11:0] scale(input logic [11:0] c, input int lv);
        logic [11:0] r;
        for (int i = 0; i < 3; i++) r[i*4 +: 4] = 4'((int'(c[i*4 +: 4]) * lv) / 16);
        return r;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_disp = 0; m_target = 0; m_t = 0; m_pend = 0; m_prev_fs = 0;
    endtask

    task automatic model_step();
        bit fs, tick;
        fs   = (bus.h_cnt == 10'd0) && (bus.v_cnt == 10'd0);
        tick = fs && !m_prev_fs;
        m_prev_fs = fs;
        case (m_phase)
            1: if (tick) begin
                m_t++;
                if (m_t == 16 * FPS) m_disp = m_target;
                if (m_t == 32 * FPS) m_phase = (m_disp == 1) ? 2 : 0;
            end
            2: if (tick && m_pend) begin
                m_pend = 0; m_target = 2; m_t = 0; m_phase = 1;
            end else if (bus.game_over) m_pend = 1;
            default: if (tick && m_pend) begin
                m_pend = 0; m_target = (m_disp == 0) ? 1 : 0; m_t = 0; m_phase = 1;
            end else if (bus.btn_start) m_pend = 1;
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [11:0] d;
        logic [16:0] a;
        bit          blank;
        case (m_disp)
            1:       begin d = bus.game_vga_data;  a = bus.game_pixel_addr;  end
            2:       begin d = bus.over_vga_data;  a = bus.over_pixel_addr;  end
            default: begin d = bus.start_vga_data; a = bus.start_pixel_addr; end
        endcase
        blank = (bus.h_cnt >= 10'd640) || (bus.v_cnt >= 10'd480);
        check("scene",       32'(bus.scene),       32'(m_disp));
        check("game_enable", 32'(bus.game_enable), 32'(m_phase == 2));
        check("pixel_addr",  32'(bus.pixel_addr),  32'(a));
        check("vga_data",    32'(bus.vga_data),    blank ? 32'd0 : 32'(scale(d, m_level())));
    endtask

    task automatic cyc(input int h, input int v, input bit btn, input bit go);
        @(negedge clk);
        bus.h_cnt = 10'(h);
        bus.v_cnt = 10'(v);
        bus.btn_start = btn;
        bus.game_over = go;
        if (force_fff) begin
            bus.start_vga_data = 12'hFFF;
            bus.game_vga_data  = 12'hFFF;
            bus.over_vga_data  = 12'hFFF;
        end else if (rand_data) begin
            bus.start_vga_data = 12'($urandom);
            bus.game_vga_data  = 12'($urandom);
            bus.over_vga_data  = 12'($urandom);
        end
        if (rand_data) begin
            bus.start_pixel_addr = 17'($urandom);
            bus.game_pixel_addr  = 17'($urandom);
            bus.over_pixel_addr  = 17'($urandom);
        end
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    // One frame: origin cycle(s), then random coordinates; pulses land on cycle 2.
    task automatic frame(input bit btn, input bit go);
        int n;
        n = 5 + int'($urandom_range(0, 3));
        cyc(0, 0, 0, 0);
        if ($urandom_range(0, 1) == 1) cyc(0, 0, 0, 0);
        for (int i = 1; i < n; i++)
            cyc(int'($urandom_range(0, 799)), int'($urandom_range(1, 524)), btn && i == 2, go && i == 2);
    endtask

    task automatic fff_probe(input string tag, input logic [11:0] exp);
        force_fff = 1'b1;
        cyc(100, 100, 0, 0);
        force_fff = 1'b0;
        check(tag, 32'(bus.vga_data), 32'(exp));
    endtask

    initial begin
        bus.h_cnt = 10'd10; bus.v_cnt = 10'd10;
        bus.btn_start = 1'b0; bus.game_over = 1'b0;
        bus.start_vga_data = 12'hABC; bus.game_vga_data = 12'h123; bus.over_vga_data = 12'h456;
        bus.start_pixel_addr = 17'h1_0001; bus.game_pixel_addr = 17'h0_2002;
        bus.over_pixel_addr = 17'h0_3003;
        model_reset();

        // Reset state and pass-through / blanking at full level
        #12;
        check("rst_scene", 32'(bus.scene), 32'd0);
        check("rst_ge", 32'(bus.game_enable), 32'd0);
        check("rst_addr", 32'(bus.pixel_addr), 32'h1_0001);
        check("rst_vga", 32'(bus.vga_data), 32'hABC);
        @(negedge clk);
        rst = 1'b0;
        cyc(10, 10, 0, 0);
        check("idle_abc", 32'(bus.vga_data), 32'hABC);
        cyc(700, 10, 0, 0);
        check("blank_h700", 32'(bus.vga_data), 32'h000);
        cyc(10, 480, 0, 0);
        check("blank_v480", 32'(bus.vga_data), 32'h000);
        rand_data = 1'b1;
        repeat (3) frame(0, 1);

        // Start: pend mid-frame, fade begins on the next tick
        frame(1, 0);
        frame(0, 0);
        repeat (16) frame(1, 1);
        fff_probe("level8_fff", 12'h777);
        repeat (15) frame(1, 0);
        check("scene_before_0", 32'(bus.scene), 32'd0);
        frame(0, 0);
        check("scene_at_0", 32'(bus.scene), 32'd1);
        fff_probe("level0_fff", 12'h000);
        repeat (31) frame(0, 0);
        check("ge_before_64", 32'(bus.game_enable), 32'd0);
        frame(0, 0);
        check("ge_at_64", 32'(bus.game_enable), 32'd1);
        fff_probe("game_full", 12'hFFF);

        // Game: btn alone ignored, btn+game_over together honoured
        repeat (2) frame(1, 0);
        check("game_btn_ign", 32'(bus.game_enable), 32'd1);
        frame(1, 1);
        frame(0, 0);
        check("ge_fade_out", 32'(bus.game_enable), 32'd0);
        repeat (63) frame(1, 1);
        frame(0, 0);
        check("over_scene", 32'(bus.scene), 32'd2);

        // Over: no stale start pend from the fade
        repeat (4) frame(0, 1);
        fff_probe("over_full", 12'hFFF);
        frame(1, 0);
        frame(0, 0);
        repeat (64) frame(0, 0);
        check("back_start", 32'(bus.scene), 32'd0);
        repeat (2) frame(0, 1);
        fff_probe("start_go_ign", 12'hFFF);

        // Reset in the middle of a fade-out at level 5
        frame(1, 0);
        frame(0, 0);
        repeat (22) frame(0, 0);
        fff_probe("level5_fff", 12'h444);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_scene", 32'(bus.scene), 32'd0);
        check("arst_vga", 32'(bus.vga_data), 32'(bus.start_vga_data));
        check_outputs();
        @(negedge clk);
        bus.h_cnt = 10'd10; bus.v_cnt = 10'd10; bus.btn_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) frame(0, 0);
        fff_probe("post_rst_full", 12'hFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/scene_sequencer.md
Name: scene_sequencer

Overview:
- Top-level scene controller for the VGA pipeline. It sequences the title (start) scene, the game scene and the game-over scene.
- Muxes the three scenes' pixel_addr/vga_data onto the single shared image-ROM address bus and VGA data path.
- Applies a frame-synchronous fade-out/fade-in brightness ramp on every scene change.
- Sits between the scene renderers and the vga_controller output stage.

Parameters:
- FRAMES_PER_STEP, 2, frame ticks spent at each brightness level during a fade (1..15).
- H_VISIBLE, 640, visible horizontal pixels.
- V_VISIBLE, 480, visible lines.

Ports:
- clk  input  1  system clock (100 MHz; h_cnt/v_cnt advance slower than clk)
- rst  input  1  asynchronous, active-high reset
- h_cnt  input  10  current VGA column
- v_cnt  input  10  current VGA line
- btn_start  input  1  debounced one-cycle start pulse
- game_over  input  1  one-cycle pulse from game logic
- start_vga_data  input  12  start-scene RGB444
- start_pixel_addr  input  17  start-scene ROM address
- game_vga_data  input  12  game-scene RGB444
- game_pixel_addr  input  17  game-scene ROM address
- over_vga_data  input  12  game-over RGB444
- over_pixel_addr  input  17  game-over ROM address
- pixel_addr  output  17  shared ROM address (combinational mux)
- vga_data  output  12  faded RGB444 to output stage (combinational)
- scene  output  2  displayed scene: 0 START, 1 GAME, 2 OVER
- game_enable  output  1  high only in state GAME

Behaviour:
- Frame tick:
  - frame_start = (h_cnt==0 && v_cnt==0).
  - Register frame_start_d each clk; frame_tick = frame_start && !frame_start_d, one clk pulse per frame.
- Registers: state, disp_scene[1:0], target_scene[1:0], level[4:0] (0..16), step_cnt[3:0], start_pend.
- Reset values: state=S_START, disp_scene=0, target_scene=0, level=16, step_cnt=0, start_pend=0.
- Reset outputs: scene=0, game_enable=0, pixel_addr=start_pixel_addr, vga_data=scaled start data at level 16.
- States:
  - S_START: btn_start sets start_pend. On frame_tick with start_pend: clear start_pend, set target_scene=GAME, step_cnt=0, go to S_FADE_OUT.
  - S_FADE_OUT: on each frame_tick, step_cnt++. When step_cnt reaches FRAMES_PER_STEP-1: step_cnt=0, level--. If level is 1 at that step, level becomes 0, disp_scene=target_scene, go to S_FADE_IN.
  - S_FADE_IN: mirror of fade-out, level++. On reaching 16, go to S_GAME if disp_scene==GAME, else S_OVER if OVER, else S_START.
  - S_GAME: game_enable=1. game_over sets an over pending bit. On the next frame_tick: target_scene=OVER, go to S_FADE_OUT.
  - S_OVER: btn_start pending, then on frame_tick: target_scene=START, go to S_FADE_OUT.
- Fade timing: a full fade-out plus fade-in takes exactly 32*FRAMES_PER_STEP frame ticks. disp_scene changes only at level 0, i.e. on a frame boundary (no tearing).
- Ignored inputs:
  - btn_start and game_over are ignored in S_FADE_OUT/S_FADE_IN; pending bits are not set.
  - btn_start is ignored in S_GAME.
  - game_over is ignored outside S_GAME.
- Simultaneous events: btn_start and game_over in the same cycle in S_GAME → game_over honoured.
- Mux:
  - pixel_addr selected by disp_scene; value 3 is unreachable and maps to start.
  - scene = disp_scene.
- Scaling:
  - Per 4-bit channel, out = (c*level)>>4, using a 9-bit product.
  - level 16 → identity; level 0 → 0.
- Blanking: if h_cnt>=H_VISIBLE or v_cnt>=V_VISIBLE, vga_data=12'h000 regardless of level.
- Reset mid-fade: returns immediately to S_START, full brightness, start scene.

Decomposition:
- Shared package/header:
  - Scene codes SCENE_START=2'd0, SCENE_GAME=2'd1, SCENE_OVER=2'd2.
  - State encodings S_START, S_FADE_OUT, S_FADE_IN, S_GAME, S_OVER.
  - LEVEL_MAX=16.
- One natural sub-module: rgb_dimmer (combinational 12-bit colour × 5-bit level scaler, three channel multipliers).

Test Plan:
1. Reset release, FRAMES_PER_STEP=2, no inputs → scene=0, level=16, start_vga_data=12'hABC passes as vga_data=12'hABC inside visible area; h_cnt=700 → 12'h000.
2. btn_start pulse mid-frame → S_FADE_OUT begins at next frame_tick; level=8 after 16 ticks; scene switches to 1 exactly at level 0 (tick 32); game_enable=1 at tick 64; vga_data tracks game_vga_data at full level.
3. At level 8, colour 12'hFFF → vga_data=12'h777; at level 0 → 12'h000; pixel_addr follows disp_scene, not target_scene.
4. In S_GAME, btn_start and game_over in the same cycle → fade to scene=2; game_enable drops to 0 on entering S_FADE_OUT.
5. btn_start pulses during a fade → ignored; S_OVER is reached with start_pend=0. A later btn_start returns to scene=0 after 64 frame ticks.
6. rst asserted at level 5 of a fade-out → state=S_START, level=16, scene=0 asynchronously, before the next clk edge.
